// File: rtl/manual_drive_pkg.sv
// Shared encodings for the manual-transmission driving controller:
// engine state values and travel-direction values.
package manual_drive_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_START = 2'd2,
        ST_MOVE  = 2'd3
    } drive_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/drive_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick for one cycle
// while the counter sits at its last value (i.e. on the wrap edge).
module drive_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission driving controller: engine FSM, saturating speed,
// direction latch and stall pulse. Define MANUAL_TURN_SIGNAL_EN to add blinker outputs.
module manual_drive_ctrl
    import manual_drive_pkg::*;
#(
    parameter int SPEED_W    = 8,
    parameter int SPEED_MAX  = 200,
    parameter int ACCEL_STEP = 1,
    parameter int DECEL_STEP = 2,
    parameter int TICK_DIV   = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               power_on,
    input  logic               power_off,
    input  logic               throttle,
    input  logic               clutch,
    input  logic               brake,
    input  logic               reverse,
    input  logic               left,
    input  logic               right,
    output logic [1:0]         state_o,
    output logic [SPEED_W-1:0] speed,
    output logic               move_forward,
    output logic               move_backward,
    output logic               turn_left,
    output logic               turn_right,
`ifdef MANUAL_TURN_SIGNAL_EN
    output logic               signal_left,
    output logic               signal_right,
`endif
    output logic               stall
);

    localparam logic [SPEED_W:0] MAX_EXT  = (SPEED_W+1)'(SPEED_MAX);
    localparam logic [SPEED_W:0] ACC_EXT  = (SPEED_W+1)'(ACCEL_STEP);
    localparam logic [SPEED_W:0] DEC_EXT  = (SPEED_W+1)'(DECEL_STEP);
    localparam logic [SPEED_W:0] DEC2_EXT = (SPEED_W+1)'(2 * DECEL_STEP);

    drive_state_t       state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               dir_q;
    logic               stall_q, stall_d;
    logic               clear_speed;
    logic               tick;

    // The extra top bit keeps overflow above SPEED_MAX and underflow below 0 visible.
    function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] s);
        logic [SPEED_W:0] sum;
        sum = {1'b0, s} + ACC_EXT;
        return (sum > MAX_EXT) ? MAX_EXT[SPEED_W-1:0] : sum[SPEED_W-1:0];
    endfunction

    function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] s,
                                                   input logic [SPEED_W:0]   step);
        logic [SPEED_W:0] diff;
        diff = {1'b0, s} - step;
        return ({1'b0, s} < step) ? '0 : diff[SPEED_W-1:0];
    endfunction

    drive_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        stall_d     = 1'b0;
        clear_speed = 1'b0;
        if (en) begin
            if (power_off) begin
                state_d     = ST_OFF;
                clear_speed = 1'b1;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        if (power_on) state_d = ST_IDLE;
                    end
                    ST_IDLE: begin
                        // Brake holds the engine idle and masks both the stall and the start.
                        if (brake) begin
                            state_d = ST_IDLE;
                        end else if (throttle && !clutch) begin
                            state_d     = ST_OFF;
                            stall_d     = 1'b1;
                            clear_speed = 1'b1;
                        end else if (throttle && clutch) begin
                            state_d = ST_START;
                        end
                    end
                    ST_START: begin
                        if (brake) begin
                            state_d = ST_IDLE;
                        end else if (throttle && !clutch) begin
                            state_d = ST_MOVE;
                        end
                    end
                    ST_MOVE: begin
                        if (brake) begin
                            state_d = ST_IDLE;
                        end else if ((reverse != dir_q) && !clutch) begin
                            state_d     = ST_OFF;
                            stall_d     = 1'b1;
                            clear_speed = 1'b1;
                        end else if (clutch || !throttle) begin
                            state_d = ST_START;
                        end
                    end
                    default: state_d = ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        speed_d = speed_q;
        if (en) begin
            if (clear_speed || (state_q == ST_OFF)) begin
                speed_d = '0;
            end else if (tick) begin
                case (state_q)
                    ST_MOVE:           speed_d = sat_add(speed_q);
                    ST_IDLE, ST_START: speed_d = sat_sub(speed_q, brake ? DEC2_EXT : DEC_EXT);
                    default:           speed_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            speed_q <= '0;
            dir_q   <= DIR_FWD;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            stall_q <= stall_d;
            // Direction only follows the lever while the car is standing still.
            if (en && (speed_q == '0)) dir_q <= reverse;
        end
    end

    assign state_o       = state_q;
    assign speed         = speed_q;
    assign stall         = stall_q;
    assign move_forward  = en && (speed_q != '0) && (dir_q == DIR_FWD);
    assign move_backward = en && (speed_q != '0) && (dir_q == DIR_REV);
    assign turn_left     = en && left && !right && (state_q != ST_OFF);
    assign turn_right    = en && right && !left && (state_q != ST_OFF);

`ifdef MANUAL_TURN_SIGNAL_EN
    logic [2:0] blink_cnt_q;
    logic       sig_l_q, sig_r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            sig_l_q     <= 1'b0;
            sig_r_q     <= 1'b0;
        end else begin
            if (tick) blink_cnt_q <= blink_cnt_q + 3'd1;
            if (!turn_left) sig_l_q <= 1'b0;
            else if (tick && (blink_cnt_q == 3'd7)) sig_l_q <= !sig_l_q;
            if (!turn_right) sig_r_q <= 1'b0;
            else if (tick && (blink_cnt_q == 3'd7)) sig_r_q <= !sig_r_q;
        end
    end

    assign signal_left  = sig_l_q;
    assign signal_right = sig_r_q;
`endif

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl with TICK_DIV=4, SPEED_MAX=20.
// Speed updates land on every 4th clock edge after reset release.
module tb_manual_drive_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, power_on, power_off, throttle, clutch, brake, reverse, left, right;
    logic [1:0] state_o;
    logic [7:0] speed;
    logic       move_forward, move_backward, turn_left, turn_right, stall;
`ifdef MANUAL_TURN_SIGNAL_EN
    logic       signal_left, signal_right;
`endif

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    manual_drive_ctrl #(
        .SPEED_W(8), .SPEED_MAX(20), .ACCEL_STEP(1), .DECEL_STEP(2), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .power_on(power_on), .power_off(power_off),
        .throttle(throttle), .clutch(clutch), .brake(brake), .reverse(reverse),
        .left(left), .right(right), .state_o(state_o), .speed(speed),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right),
`ifdef MANUAL_TURN_SIGNAL_EN
        .signal_left(signal_left), .signal_right(signal_right),
`endif
        .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic step_to_tick();
        do step(); while (ecnt % 4 != 0);
    endtask

    // Power-cycle, climb OFF->IDLE->START->MOVE, then accelerate for n ticks.
    task automatic go_move(input int n);
        int k;
        throttle = 0; clutch = 0; brake = 0; reverse = 0; power_off = 1;
        step();
        power_off = 0; power_on = 1;
        step();
        power_on = 0; throttle = 1; clutch = 1;
        step();
        clutch = 0;
        step();
        k = 0;
        while (k < n) begin
            step();
            if (ecnt % 4 == 0) k++;
        end
    endtask

    task automatic test_reset();
        rst = 1; en = 1; power_on = 1; power_off = 1; throttle = 1; clutch = 1;
        brake = 1; reverse = 1; left = 1; right = 1;
        repeat (3) step();
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        total++; if (speed !== 8'd0) begin bad++; $display("FAIL reset_speed: got %0d want 0", speed); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
        total++; if ({move_forward, move_backward, turn_left, turn_right} !== 4'b0000) begin
            bad++; $display("FAIL reset_motion: got %b want 0000", {move_forward, move_backward, turn_left, turn_right});
        end
        power_on = 0; power_off = 0; throttle = 0; clutch = 0; brake = 0; reverse = 0;
        left = 0; right = 0;
        rst = 0;
        ecnt = 0;
    endtask

    task automatic test_idle_stall();
        power_on = 1;
        step();
        power_on = 0;
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL power_on_idle: got %0d want 1", state_o); end
        throttle = 1; clutch = 0;
        step();
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL idle_stall_state: got %0d want 0", state_o); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL idle_stall_pulse: got %0b want 1", stall); end
        throttle = 0;
        step();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_one_cycle: got %0b want 0", stall); end
    endtask

    task automatic test_accel();
        int k;
        power_on = 1;
        step();
        power_on = 0; throttle = 1; clutch = 1;
        step();
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL idle_to_start: got %0d want 2", state_o); end
        clutch = 0;
        step();
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL start_to_move: got %0d want 3", state_o); end
        k = 0;
        while (k < 10) begin step(); if (ecnt % 4 == 0) k++; end
        total++; if (speed !== 8'd10) begin bad++; $display("FAIL accel_10: got %0d want 10", speed); end
        total++; if (move_forward !== 1'b1 || move_backward !== 1'b0) begin
            bad++; $display("FAIL move_fwd: got fwd=%0b bwd=%0b want fwd=1 bwd=0", move_forward, move_backward);
        end
        k = 0;
        while (k < 20) begin step(); if (ecnt % 4 == 0) k++; end
        total++; if (speed !== 8'd20) begin bad++; $display("FAIL accel_sat: got %0d want 20", speed); end
    endtask

    task automatic test_reverse();
        go_move(5);
        total++; if (speed !== 8'd5) begin bad++; $display("FAIL rev_setup_speed: got %0d want 5", speed); end
        reverse = 1;
        step();
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rev_stall_state: got %0d want 0", state_o); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rev_stall_pulse: got %0b want 1", stall); end
        total++; if (speed !== 8'd0) begin bad++; $display("FAIL rev_stall_speed: got %0d want 0", speed); end
        go_move(5);
        clutch = 1; reverse = 1;
        step();
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL rev_clutch_state: got %0d want 2", state_o); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rev_clutch_nostall: got %0b want 0", stall); end
        total++; if (speed !== 8'd5) begin bad++; $display("FAIL rev_clutch_speed: got %0d want 5", speed); end
        step();
        total++; if (move_forward !== 1'b1 || move_backward !== 1'b0) begin
            bad++; $display("FAIL rev_dir_frozen: got fwd=%0b bwd=%0b want fwd=1 bwd=0", move_forward, move_backward);
        end
        reverse = 0; clutch = 0;
    endtask

    task automatic test_brake();
        logic [7:0] exp_sp [4];
        exp_sp[0] = 8'd6; exp_sp[1] = 8'd2; exp_sp[2] = 8'd0; exp_sp[3] = 8'd0;
        go_move(10);
        brake = 1; throttle = 0;
        step();
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL brake_idle: got %0d want 1", state_o); end
        total++; if (speed !== 8'd10) begin bad++; $display("FAIL brake_hold_speed: got %0d want 10", speed); end
        for (int i = 0; i < 4; i++) begin
            step_to_tick();
            total++; if (speed !== exp_sp[i]) begin
                bad++; $display("FAIL brake_decel_%0d: got %0d want %0d", i, speed, exp_sp[i]);
            end
        end
        brake = 0;
    endtask

    task automatic test_turn_and_enable();
        left = 1; right = 1; #1;
        total++; if (turn_left !== 1'b0 || turn_right !== 1'b0) begin
            bad++; $display("FAIL turn_both: got l=%0b r=%0b want 0 0", turn_left, turn_right);
        end
        right = 0; #1;
        total++; if (turn_left !== 1'b1 || turn_right !== 1'b0) begin
            bad++; $display("FAIL turn_left_only: got l=%0b r=%0b want 1 0", turn_left, turn_right);
        end
        left = 0; right = 1; #1;
        total++; if (turn_left !== 1'b0 || turn_right !== 1'b1) begin
            bad++; $display("FAIL turn_right_only: got l=%0b r=%0b want 0 1", turn_left, turn_right);
        end
        right = 0;
        power_off = 1; throttle = 1; clutch = 1;
        step();
        total++; if (state_o !== 2'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL power_off_prio: got state=%0d stall=%0b want 0 0", state_o, stall);
        end
        power_off = 0; throttle = 0; clutch = 0;
        go_move(3);
        left = 1; en = 0; #1;
        total++; if (move_forward !== 1'b0 || turn_left !== 1'b0) begin
            bad++; $display("FAIL en_off_outputs: got fwd=%0b l=%0b want 0 0", move_forward, turn_left);
        end
        power_off = 1;
        repeat (8) step();
        total++; if (state_o !== 2'd3 || speed !== 8'd3) begin
            bad++; $display("FAIL en_off_hold: got state=%0d speed=%0d want 3 3", state_o, speed);
        end
        power_off = 0; en = 1; #1;
        total++; if (move_forward !== 1'b1 || turn_left !== 1'b1) begin
            bad++; $display("FAIL en_on_resume: got fwd=%0b l=%0b want 1 1", move_forward, turn_left);
        end
        left = 0;
    endtask

    initial begin
        test_reset();
        test_idle_stall();
        test_accel();
        test_reverse();
        test_brake();
        test_turn_and_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
